// File: rtl/scandoubler_rotate_pkg.sv
// Shared types and helpers for the rotating scandoubler SDRAM arbiter.
// Holds the arbiter states, the grant type and the cornerturn address packer.
package scandoubler_rotate_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETTLE,
    S_WR_ISSUE,
    S_RD_ISSUE,
    S_RD_DRAIN
  } state_e;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  localparam int unsigned WR_BURST_DEF = 16;
  localparam int unsigned RD_BURST_DEF = 8;
  localparam int unsigned PACK_W       = 21;

  // Writes pass (col, row), reads pass (row, x): that swap is the rotation.
  function automatic logic [PACK_W-1:0] pack_addr(input logic       frame,
                                                  input logic [9:0] major,
                                                  input logic [9:0] minor);
    return {frame, major, minor};
  endfunction

endpackage

// File: rtl/scandoubler_rotate_memarb.sv
// Arbitrates one word-level SDRAM port between the scandoubler's write stream
// (16-word bursts) and its rotated read stream (8-word bursts).
module scandoubler_rotate_memarb
  import scandoubler_rotate_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 24'h200000,
  parameter int unsigned           WR_BURST   = WR_BURST_DEF,
  parameter int unsigned           RD_BURST   = RD_BURST_DEF,
  parameter int unsigned           WR_SETTLE  = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  vidin_req,
  input  logic                  vidin_frame,
  input  logic [9:0]            vidin_row,
  input  logic [9:0]            vidin_col,
  input  logic [15:0]           vidin_d,
  output logic                  vidin_ack,
  input  logic                  vidout_req,
  input  logic                  vidout_frame,
  input  logic [9:0]            vidout_row,
  input  logic [9:0]            vidout_col,
  output logic [15:0]           vidout_d,
  output logic                  vidout_ack,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  input  logic                  ram_ack,
  input  logic [15:0]           ram_rdata,
  input  logic                  ram_rvalid
);

  localparam int unsigned WCW = (WR_BURST > 1) ? $clog2(WR_BURST) : 1;
  localparam int unsigned RCW = (RD_BURST > 1) ? $clog2(RD_BURST) : 1;
  localparam int unsigned OCW = $clog2(RD_BURST + 1);
  localparam int unsigned SCW = $clog2(WR_SETTLE + 1);

  state_e                r_state;
  grant_e                r_last_grant;
  logic [WCW-1:0]        r_wcnt;
  logic [RCW-1:0]        r_rcnt;
  logic [SCW-1:0]        r_scnt;
  logic [OCW-1:0]        r_outstanding;
  logic [9:0]            r_rd_x;
  logic [9:0]            r_rd_row;
  logic                  r_rd_frame;
  logic                  r_ram_req;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [15:0]           r_ram_wdata;
  logic [15:0]           r_vidout_d;
  logic                  r_vidout_ack;

  logic                  w_wr_ack;
  logic                  w_rd_ack;
  logic                  w_rvalid;
  logic                  w_grant_wr;
  logic [9:0]            w_rd_x_nxt;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_first;
  logic [ADDR_WIDTH-1:0] w_rd_next;

  assign w_wr_ack   = r_ram_req & ram_ack & r_ram_we;
  assign w_rd_ack   = r_ram_req & ram_ack & ~r_ram_we;
  // Stray rvalid with nothing in flight (e.g. after a reset) is dropped here.
  assign w_rvalid   = ram_rvalid & (r_outstanding != '0);
  assign w_grant_wr = vidin_req & (~vidout_req | (r_last_grant == GRANT_READ));
  assign w_rd_x_nxt = r_rd_x + 10'd1;

  assign w_wr_addr  = BASE_ADDR + ADDR_WIDTH'(pack_addr(vidin_frame, vidin_col, vidin_row));
  assign w_rd_first = BASE_ADDR + ADDR_WIDTH'(pack_addr(vidout_frame, vidout_row, vidout_col));
  assign w_rd_next  = BASE_ADDR + ADDR_WIDTH'(pack_addr(r_rd_frame, r_rd_row, w_rd_x_nxt));

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values and block ordering cannot change behaviour.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_READ;
      r_wcnt       <= '0;
      r_rcnt       <= '0;
      r_scnt       <= '0;
      r_rd_x       <= '0;
      r_rd_row     <= '0;
      r_rd_frame   <= 1'b0;
      r_ram_req    <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_wr) begin
            r_state <= S_WR_SETTLE;
            r_scnt  <= '0;
          end else if (vidout_req) begin
            r_state    <= S_RD_ISSUE;
            r_rd_x     <= vidout_col;
            r_rd_row   <= vidout_row;
            r_rd_frame <= vidout_frame;
            r_rcnt     <= '0;
            r_ram_req  <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_addr <= w_rd_first;
          end
        end
        S_WR_SETTLE: begin
          if (!vidin_req) begin
            r_state      <= S_IDLE;
            r_wcnt       <= '0;
            r_last_grant <= GRANT_WRITE;
          end else if (r_scnt == SCW'(WR_SETTLE - 1)) begin
            r_state     <= S_WR_ISSUE;
            r_ram_req   <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= w_wr_addr;
            r_ram_wdata <= vidin_d;
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end
        S_WR_ISSUE: begin
          if (w_wr_ack) begin
            r_ram_req <= 1'b0;
            r_ram_we  <= 1'b0;
            if (r_wcnt == WCW'(WR_BURST - 1) || !vidin_req) begin
              r_state      <= S_IDLE;
              r_wcnt       <= '0;
              r_last_grant <= GRANT_WRITE;
            end else begin
              r_state <= S_WR_SETTLE;
              r_wcnt  <= r_wcnt + 1'b1;
              r_scnt  <= '0;
            end
          end
        end
        S_RD_ISSUE: begin
          if (w_rd_ack) begin
            r_rd_x <= w_rd_x_nxt;
            r_rcnt <= r_rcnt + 1'b1;
            if (r_rcnt == RCW'(RD_BURST - 1) || !vidout_req) begin
              r_state   <= S_RD_DRAIN;
              r_ram_req <= 1'b0;
            end else begin
              r_ram_addr <= w_rd_next;
            end
          end
        end
        S_RD_DRAIN: begin
          if (r_outstanding == '0) begin
            r_state      <= S_IDLE;
            r_rcnt       <= '0;
            r_last_grant <= GRANT_READ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read returns arrive in issue order; forwarded even if vidout_req dropped.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
      r_vidout_ack  <= 1'b0;
      r_vidout_d    <= '0;
    end else begin
      case ({w_rd_ack, w_rvalid})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      r_vidout_ack <= w_rvalid;
      if (w_rvalid) r_vidout_d <= ram_rdata;
    end
  end

  assign vidin_ack  = w_wr_ack;
  assign vidout_d   = r_vidout_d;
  assign vidout_ack = r_vidout_ack;
  assign ram_req    = r_ram_req;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_scandoubler_rotate_memarb.sv
// Directed bench for scandoubler_rotate_memarb: a zero-wait SDRAM stub acks
// every request and returns read data three cycles later.
module tb_scandoubler_rotate_memarb;
  import scandoubler_rotate_pkg::*;

  logic        clk_sys;
  logic        reset_n;
  logic        vidin_req, vidin_frame;
  logic [9:0]  vidin_row, vidin_col;
  logic [15:0] vidin_d;
  logic        vidin_ack;
  logic        vidout_req, vidout_frame;
  logic [9:0]  vidout_row, vidout_col;
  logic [15:0] vidout_d;
  logic        vidout_ack;
  logic        ram_req, ram_we, ram_ack, ram_rvalid;
  logic [23:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  logic        w2_vidin_ack, w2_vidout_ack, w2_ram_req, w2_ram_we;
  logic [15:0] w2_vidout_d, w2_ram_wdata;
  logic [23:0] w2_ram_addr;

  logic             spur_rv = 1'b0;
  logic [2:0]       rv_pipe = '0;
  logic [2:0][15:0] rd_pipe = '0;
  int               cyc_cnt = 0;
  int               checks  = 0;
  int               errors  = 0;

  scandoubler_rotate_memarb u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
    .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
    .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
    .vidout_col(vidout_col), .vidout_d(vidout_d), .vidout_ack(vidout_ack),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid)
  );

  // Second instance with a base near the top of memory to observe wrapping.
  scandoubler_rotate_memarb #(.BASE_ADDR(24'hFFFFFC)) u_wrap (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
    .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(w2_vidin_ack),
    .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
    .vidout_col(vidout_col), .vidout_d(w2_vidout_d), .vidout_ack(w2_vidout_ack),
    .ram_req(w2_ram_req), .ram_we(w2_ram_we), .ram_addr(w2_ram_addr), .ram_wdata(w2_ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  assign ram_ack    = ram_req;
  assign ram_rvalid = rv_pipe[2] | spur_rv;
  assign ram_rdata  = rd_pipe[2];

  always @(posedge clk_sys) begin
    cyc_cnt <= cyc_cnt + 1;
    rv_pipe <= {rv_pipe[1:0], ram_req & ram_ack & ~ram_we};
    rd_pipe <= {rd_pipe[1:0], ram_addr[15:0] ^ 16'hA5A5};
  end

  task automatic do_reset();
    reset_n    = 1'b0;
    vidin_req  = 1'b0;
    vidout_req = 1'b0;
    spur_rv    = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    vidin_req = 1'b0; vidin_frame = 1'b0; vidin_row = '0; vidin_col = '0; vidin_d = '0;
    vidout_req = 1'b0; vidout_frame = 1'b0; vidout_row = '0; vidout_col = '0;
    #1;
    checks++;
    if ({ram_req, ram_we, ram_addr, ram_wdata, vidin_ack, vidout_ack, vidout_d} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wd=%h vack=%b oack=%b od=%h want all 0",
               ram_req, ram_we, ram_addr, ram_wdata, vidin_ack, vidout_ack, vidout_d);
    end
    checks++;
    if (u_dut.r_state !== S_IDLE || u_dut.r_last_grant !== GRANT_READ || u_dut.r_outstanding !== '0) begin
      errors++;
      $display("FAIL reset_state got state=%0d last=%0d outst=%0d want 0 0 0",
               u_dut.r_state, u_dut.r_last_grant, u_dut.r_outstanding);
    end
    do_reset();
  endtask

  task automatic test_write_only();
    int k = 0;
    int last = 0;
    do_reset();
    vidin_frame = 1'b1; vidin_row = 10'd5; vidin_col = 10'h1F0; vidin_d = 16'hC000;
    vidin_req = 1'b1;
    for (int c = 0; c < 400 && k < 16; c++) begin
      @(negedge clk_sys);
      if (ram_req && ram_ack) begin
        checks++;
        if (vidin_ack !== 1'b1 || ram_we !== 1'b1) begin
          errors++;
          $display("FAIL wr_ack word %0d got vidin_ack=%b we=%b want 1 1", k, vidin_ack, ram_we);
        end
        checks++;
        if (ram_addr !== 24'h37C005 + 24'(k * 1024)) begin
          errors++;
          $display("FAIL wr_addr word %0d got %h want %h", k, ram_addr, 24'h37C005 + 24'(k * 1024));
        end
        checks++;
        if (ram_wdata !== 16'hC000 + 16'(k)) begin
          errors++;
          $display("FAIL wr_data word %0d got %h want %h", k, ram_wdata, 16'hC000 + 16'(k));
        end
        if (k > 0) begin
          checks++;
          if (cyc_cnt - last < 3) begin
            errors++;
            $display("FAIL wr_gap word %0d got %0d cycles want >=3", k, cyc_cnt - last);
          end
        end
        last = cyc_cnt;
        k++;
        @(posedge clk_sys);
        #1;
        if (k == 16) vidin_req = 1'b0;
        else begin
          vidin_col = vidin_col + 10'd1;
          vidin_d   = vidin_d + 16'd1;
        end
      end
    end
    checks++;
    if (k != 16) begin
      errors++;
      $display("FAIL wr_count got %0d want 16", k);
    end
    repeat (4) @(negedge clk_sys);
    checks++;
    if (ram_req !== 1'b0 || vidin_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_end got req=%b vack=%b want 0 0", ram_req, vidin_ack);
    end
    checks++;
    if (u_dut.r_last_grant !== GRANT_WRITE) begin
      errors++;
      $display("FAIL wr_last_grant got %0d want %0d", u_dut.r_last_grant, GRANT_WRITE);
    end
  endtask

  task automatic test_read_only();
    int i = 0;
    int j = 0;
    logic [23:0] exp_a;
    logic [15:0] exp_d;
    do_reset();
    vidout_frame = 1'b0; vidout_row = 10'd7; vidout_col = 10'd0;
    vidout_req = 1'b1;
    for (int c = 0; c < 400 && j < 9; c++) begin
      @(negedge clk_sys);
      if (vidout_ack) begin
        exp_d = (j < 8) ? ((16'h1C00 + 16'(j)) ^ 16'hA5A5) : (16'h1C40 ^ 16'hA5A5);
        checks++;
        if (vidout_d !== exp_d) begin
          errors++;
          $display("FAIL rd_data %0d got %h want %h", j, vidout_d, exp_d);
        end
        j++;
        if (j == 8) vidout_col = 10'h040;
      end
      if (ram_req && ram_ack && !ram_we) begin
        exp_a = (i < 8) ? (24'h201C00 + 24'(i)) : 24'h201C40;
        checks++;
        if (ram_addr !== exp_a) begin
          errors++;
          $display("FAIL rd_addr %0d got %h want %h", i, ram_addr, exp_a);
        end
        if (i >= 8) begin
          checks++;
          if (j < 8) begin
            errors++;
            $display("FAIL rd_burst_len got new burst with %0d returns want 8", j);
          end
          vidout_req = 1'b0;
        end
        i++;
      end
    end
    repeat (6) @(negedge clk_sys);
    checks++;
    if (i != 9 || j != 9 || ram_req !== 1'b0) begin
      errors++;
      $display("FAIL rd_count got issued=%0d returned=%0d req=%b want 9 9 0", i, j, ram_req);
    end
  endtask

  task automatic test_early_stop();
    int i = 0;
    int j = 0;
    do_reset();
    vidout_frame = 1'b1; vidout_row = 10'd2; vidout_col = 10'h010;
    vidout_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_sys);
      if (vidout_ack) begin
        checks++;
        if (vidout_d !== ((16'h0810 + 16'(j)) ^ 16'hA5A5)) begin
          errors++;
          $display("FAIL es_data %0d got %h want %h", j, vidout_d, (16'h0810 + 16'(j)) ^ 16'hA5A5);
        end
        j++;
      end
      if (ram_req && ram_ack && !ram_we) begin
        checks++;
        if (i >= 3 || ram_addr !== 24'h300810 + 24'(i)) begin
          errors++;
          $display("FAIL es_issue %0d got %h want <=3 reads at 300810+n", i, ram_addr);
        end
        if (i == 2) vidout_req = 1'b0;
        i++;
      end
    end
    checks++;
    if (i != 3 || j != 3 || u_dut.r_state !== S_IDLE) begin
      errors++;
      $display("FAIL es_count got issued=%0d returned=%0d state=%0d want 3 3 0", i, j, u_dut.r_state);
    end
  endtask

  task automatic test_contention();
    grant_e order[$];
    grant_e t;
    grant_e exp_order [4] = '{GRANT_WRITE, GRANT_READ, GRANT_WRITE, GRANT_READ};
    int     wk = 0;
    int     raise_cyc;
    logic   drop = 1'b0;
    reset_n = 1'b0;
    vidin_frame = 1'b0; vidin_row = 10'd3; vidin_col = 10'd0; vidin_d = 16'h0000;
    vidout_frame = 1'b0; vidout_row = 10'd1; vidout_col = 10'd0;
    vidin_req = 1'b1; vidout_req = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    raise_cyc = cyc_cnt;
    for (int c = 0; c < 600 && order.size() < 4; c++) begin
      @(negedge clk_sys);
      if (ram_req && ram_ack) begin
        t = ram_we ? GRANT_WRITE : GRANT_READ;
        if (order.size() == 0 || order[order.size()-1] != t) begin
          order.push_back(t);
          if (t == GRANT_WRITE) begin
            checks++;
            if (cyc_cnt - raise_cyc > 24) begin
              errors++;
              $display("FAIL ct_wr_wait got %0d cycles want <=24", cyc_cnt - raise_cyc);
            end
          end
        end
        if (ram_we) begin
          wk++;
          drop = (wk % 16 == 0);
          if (drop) begin
            @(posedge clk_sys);
            #1 vidin_req = 1'b0;
            @(negedge clk_sys);
            vidin_req = 1'b1; vidin_col = 10'd0; vidin_d = 16'h0000;
            raise_cyc = cyc_cnt;
          end else begin
            @(posedge clk_sys);
            #1 vidin_col = vidin_col + 10'd1;
            vidin_d = vidin_d + 16'd1;
          end
        end
      end
    end
    vidin_req = 1'b0; vidout_req = 1'b0;
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL ct_bursts got %0d want 4", order.size());
    end
    for (int n = 0; n < 4 && n < order.size(); n++) begin
      checks++;
      if (order[n] !== exp_order[n]) begin
        errors++;
        $display("FAIL ct_order %0d got %0d want %0d", n, order[n], exp_order[n]);
      end
    end
    repeat (16) @(negedge clk_sys);
  endtask

  task automatic test_reset_mid_write();
    int   wk = 0;
    logic seen_oack = 1'b0;
    do_reset();
    vidin_frame = 1'b0; vidin_row = 10'd9; vidin_col = 10'd0; vidin_d = 16'h5000;
    vidin_req = 1'b1;
    for (int c = 0; c < 200 && wk < 5; c++) begin
      @(negedge clk_sys);
      if (ram_req && ram_ack && ram_we) begin
        wk++;
        @(posedge clk_sys);
        #1 vidin_col = vidin_col + 10'd1;
        vidin_d = vidin_d + 16'd1;
      end
    end
    for (int c = 0; c < 20 && !ram_req; c++) @(negedge clk_sys);
    checks++;
    if (ram_req !== 1'b1 || wk != 5) begin
      errors++;
      $display("FAIL rst_pre got req=%b acks=%0d want 1 5", ram_req, wk);
    end
    #1 reset_n = 1'b0;
    vidin_req = 1'b0;
    #1;
    checks++;
    if ({ram_req, ram_we, ram_addr, ram_wdata, vidin_ack, vidout_ack, vidout_d} !== '0) begin
      errors++;
      $display("FAIL rst_mid got req=%b we=%b addr=%h wd=%h vack=%b want all 0",
               ram_req, ram_we, ram_addr, ram_wdata, vidin_ack);
    end
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    @(negedge clk_sys);
    spur_rv = 1'b1;
    @(negedge clk_sys);
    spur_rv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_sys);
      if (vidout_ack !== 1'b0) seen_oack = 1'b1;
    end
    checks++;
    if (seen_oack || ram_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_spurious got vidout_ack=%b req=%b want 0 0", seen_oack, ram_req);
    end
  endtask

  task automatic test_addr_wrap();
    logic [23:0] wrap_tbl [8] = '{24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF,
                                 24'h000000, 24'h000001, 24'h000002, 24'h000003};
    int i = 0;
    do_reset();
    vidout_frame = 1'b0; vidout_row = 10'd0; vidout_col = 10'd0;
    vidout_req = 1'b1;
    for (int c = 0; c < 100 && i < 8; c++) begin
      @(negedge clk_sys);
      if (w2_ram_req && ram_ack && !w2_ram_we) begin
        checks++;
        if (w2_ram_addr !== wrap_tbl[i]) begin
          errors++;
          $display("FAIL wrap_addr %0d got %h want %h", i, w2_ram_addr, wrap_tbl[i]);
        end
        if (i == 7) vidout_req = 1'b0;
        i++;
      end
    end
    checks++;
    if (i != 8) begin
      errors++;
      $display("FAIL wrap_count got %0d want 8", i);
    end
    repeat (8) @(negedge clk_sys);
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_read_only();
    test_early_stop();
    test_contention();
    test_reset_mid_write();
    test_addr_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
